// File: rtl/tff_toggle_gen.sv
// tff_toggle_gen: debounced pushbutton to single-cycle toggle pulses with optional auto-repeat
module tff_toggle_gen #(
  parameter int DEBOUNCE      = 4,
  parameter int HOLD_DELAY    = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int CW            = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic rep_en,
  output logic t,
  output logic btn_db,
  output logic rep_active
);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_e;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] DB_C = CW'(DEBOUNCE);
  localparam logic [CW-1:0] HD_C = CW'(HOLD_DELAY);
  localparam logic [CW-1:0] RP_C = CW'(REPEAT_PERIOD);
  state_e state_q, state_d;
  logic sync1_q, sync2_q, db_q, db_d, prev_q, t_q, t_d, rep_q;
  logic [CW-1:0] stab_q, stab_d, hold_q, hold_d, rpt_q, rpt_d;
  logic [CW-1:0] stab_inc, hold_inc, rpt_inc;
  // counter increments; hold saturates so a later rep_en rise re-enters REPEAT at once
  always_comb begin
    stab_inc = stab_q + ONE;
    hold_inc = (hold_q >= HD_C) ? HD_C : hold_q + ONE;
    rpt_inc  = rpt_q + ONE;
  end
  // debounce: a level differing from btn_db must persist DEBOUNCE samples to be adopted
  always_comb begin
    db_d   = (sync2_q != db_q && stab_inc == DB_C) ? sync2_q : db_q;
    stab_d = (sync2_q == db_q || stab_inc == DB_C) ? '0 : stab_inc;
  end
  // press/hold/repeat FSM; a falling debounced level pre-empts any pulse due on that edge
  always_comb begin
    state_d = state_q;
    t_d     = 1'b0;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        rpt_d  = '0;
        if (db_q && !prev_q) begin
          state_d = HELD;
          t_d     = 1'b1;
        end
      end
      HELD: begin
        if (!db_d) begin
          state_d = IDLE;
          hold_d  = '0;
          rpt_d   = '0;
        end else begin
          hold_d = hold_inc;
          if (rep_en && hold_inc == HD_C) begin
            state_d = REPEAT;
            t_d     = 1'b1;
            rpt_d   = '0;
          end
        end
      end
      REPEAT: begin
        if (!db_d) begin
          state_d = IDLE;
          hold_d  = '0;
          rpt_d   = '0;
        end else if (!rep_en) begin
          state_d = HELD;
          hold_d  = HD_C;
        end else begin
          t_d   = (rpt_inc == RP_C);
          rpt_d = (rpt_inc == RP_C) ? '0 : rpt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously by reset low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      prev_q  <= 1'b0;
      stab_q  <= '0;
      hold_q  <= '0;
      rpt_q   <= '0;
      state_q <= IDLE;
      t_q     <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      prev_q  <= db_q;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
      state_q <= state_d;
      t_q     <= t_d;
      rep_q   <= (state_d == REPEAT);
    end
  end
  assign t          = t_q;
  assign btn_db     = db_q;
  assign rep_active = rep_q;
endmodule
